// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: splits a framed word stream into per-channel registers.
// Optional saturating frame-error counter enabled by defining TDM_DEMUX_ERRCNT_EN.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic [7:0]                err_count
);

  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [SW-1:0]      slot_r;
  logic [SW-1:0]      slot_nxt_s;
  logic               wr_en_s;
  logic [SW-1:0]      wr_slot_s;
  logic               done_nxt_s;
  logic               err_nxt_s;
  logic [CHANNELS-1:0] valid_nxt_s;

  // Frame state and slot position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SYNC;
      slot_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      slot_r  <= slot_nxt_s;
    end
  end

  // Next-state decode: which channel to write and which pulses to raise
  always_comb begin
    state_nxt_s = state_r;
    slot_nxt_s  = slot_r;
    wr_en_s     = 1'b0;
    wr_slot_s   = '0;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      SYNC: begin
        if (in_valid) begin
          if (in_sof) begin
            wr_en_s = 1'b1;
            if (CHANNELS == 1) begin
              done_nxt_s = 1'b1;
            end else begin
              state_nxt_s = RUN;
              slot_nxt_s  = SW'(1);
            end
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = SYNC;
        end
      end
      RUN: begin
        if (in_valid) begin
          wr_en_s = 1'b1;
          if (in_sof) begin
            // Early sof abandons the partial frame and restarts at slot 0
            err_nxt_s  = 1'b1;
            slot_nxt_s = SW'(1);
          end else if (slot_r == LAST_SLOT) begin
            wr_slot_s   = slot_r;
            done_nxt_s  = 1'b1;
            slot_nxt_s  = '0;
            state_nxt_s = SYNC;
          end else begin
            wr_slot_s  = slot_r;
            slot_nxt_s = slot_r + SW'(1);
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = SYNC;
        slot_nxt_s  = '0;
      end
    endcase
  end

  // One-hot strobe for the channel written this cycle
  always_comb begin
    valid_nxt_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      valid_nxt_s[k] = wr_en_s && (wr_slot_s == SW'(k));
    end
  end

  // Registered channel data and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (valid_nxt_s[k]) begin
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end
      end
      out_valid  <= valid_nxt_s;
      frame_done <= done_nxt_s;
      frame_err  <= err_nxt_s;
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  // Saturating count of framing violations, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (err_nxt_s && (err_count != 8'd255)) begin
      err_count <= err_count + 8'd1;
    end else begin
      err_count <= err_count;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed scoreboard bench for tdm_demux (CHANNELS=4 main instance, CHANNELS=1 side instance).
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sof;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic        frame_done, frame_err;
  logic [7:0]  err_count;

  logic        one_valid, one_sof;
  logic [7:0]  one_data;
  logic [7:0]  one_out_data;
  logic [0:0]  one_out_valid;
  logic        one_done, one_err;
  logic [7:0]  one_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
    logic        done;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [31:0] m_data;
  bit          m_run;
  int          m_slot;
  int          m_cnt;

  always #5 clk = ~clk;

  tdm_demux #(.CHANNELS(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .frame_done(frame_done),
    .frame_err(frame_err), .err_count(err_count)
  );

  tdm_demux #(.CHANNELS(1), .WIDTH(8)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(one_valid), .in_sof(one_sof), .in_data(one_data),
    .out_data(one_out_data), .out_valid(one_out_valid), .frame_done(one_done),
    .frame_err(one_err), .err_count(one_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 32'd0;
    m_run  = 1'b0;
    m_slot = 0;
    m_cnt  = 0;
  endtask

  // Drive one cycle, push the model's prediction, then pop and compare after the edge
  task automatic step(input bit v, input bit sof, input logic [7:0] d, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    in_valid = v; in_sof = sof; in_data = d;
    e = '0;
    if (v) begin
      if (sof) begin
        e.err = m_run;
        m_data[7:0] = d;
        e.v = 4'b0001;
        m_run = 1'b1;
        m_slot = 1;
      end else if (!m_run) begin
        e.err = 1'b1;
      end else begin
        m_data[m_slot*8 +: 8] = d;
        e.v = 4'(1 << m_slot);
        if (m_slot == 3) begin
          e.done = 1'b1;
          m_run = 1'b0;
          m_slot = 0;
        end else begin
          m_slot++;
        end
      end
    end
`ifdef TDM_DEMUX_ERRCNT_EN
    if (e.err && m_cnt < 255) m_cnt++;
`endif
    e.d = m_data;
    e.cnt = 8'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      check({tag, "_valid"}, out_valid, got.v);
      check({tag, "_data"}, out_data, got.d);
      check({tag, "_done"}, frame_done, got.done);
      check({tag, "_err"}, frame_err, got.err);
      check({tag, "_cnt"}, err_count, got.cnt);
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic frame4(input logic [31:0] w, input string tag);
    step(1'b1, 1'b1, w[7:0],   tag);
    step(1'b1, 1'b0, w[15:8],  tag);
    step(1'b1, 1'b0, w[23:16], tag);
    step(1'b1, 1'b0, w[31:24], tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'd0;
    one_valid = 1'b0; one_sof = 1'b0; one_data = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", out_data, 32'd0);
    check("rst_valid", out_valid, 4'd0);
    check("rst_done", frame_done, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_cnt", err_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame
    frame4(32'h44332211, "clean");
    check("clean_final", out_data, 32'h44332211);

    // Gaps inside a frame, then back-to-back frame
    step(1'b1, 1'b1, 8'h11, "gap");
    step(1'b1, 1'b0, 8'h22, "gap");
    step(1'b0, 1'b0, 8'hE1, "gap_idle");
    step(1'b0, 1'b1, 8'hE2, "gap_idle");
    step(1'b1, 1'b0, 8'h33, "gap");
    step(1'b1, 1'b0, 8'h44, "gap");
    frame4(32'hDDCCBBAA, "b2b");
    check("b2b_final", out_data, 32'hDDCCBBAA);

    // Early sof aborts the partial frame
    step(1'b1, 1'b1, 8'h01, "early");
    step(1'b1, 1'b0, 8'h02, "early");
    step(1'b1, 1'b1, 8'h09, "early_sof");
    check("early_err_pulse", {frame_err, out_valid}, 5'b1_0001);
    step(1'b1, 1'b0, 8'h0A, "early");
    step(1'b1, 1'b0, 8'h0B, "early");
    step(1'b1, 1'b0, 8'h0C, "early");
    check("early_final", out_data, 32'h0C0B0A09);

    // Asynchronous reset between edges after slot 1
    step(1'b1, 1'b1, 8'h71, "midrst");
    step(1'b1, 1'b0, 8'h72, "midrst");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_data", out_data, 32'd0);
    check("midrst_valid", out_valid, 4'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h73, "postrst_nosof");

    // Data before sync is dropped, then a clean frame
    step(1'b1, 1'b0, 8'h55, "presync");
    step(1'b1, 1'b0, 8'h66, "presync");
    frame4(32'h87654321, "sync_frame");
    check("sync_final", out_data, 32'h87654321);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 8'(i), "sat");
    end
`ifdef TDM_DEMUX_ERRCNT_EN
    check("sat_final", err_count, 8'd255);
`else
    check("sat_final", err_count, 8'd0);
`endif

    // Single-channel build: every sof word completes a frame
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      one_valid = 1'b1; one_sof = 1'b1; one_data = 8'(8'hA0 + i);
      @(posedge clk);
      #1;
      check("one_valid", one_out_valid, 1'b1);
      check("one_done", one_done, 1'b1);
      check("one_err", one_err, 1'b0);
      check("one_data", one_out_data, 8'(8'hA0 + i));
      check("one_cnt", one_cnt, 8'd0);
    end
    @(negedge clk);
    one_sof = 1'b0; one_data = 8'h5A;
    @(posedge clk);
    #1;
    check("one_nosof_err", {one_err, one_done, one_out_valid}, 3'b100);
    check("one_nosof_data", one_out_data, 8'hA4);
    @(negedge clk);
    one_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
